// File: rtl/cfg_frame_loader_pkg.sv
// Shared state encoding, header field layout and frame sizing for the
// configuration frame loader.
package cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETUP,
        STROBE,
        HOLD,
        ERR
    } cfg_state_t;

    // Header word layout: start frame address in the low half, frame count above it.
    localparam int ADDR_LSB = 0;
    localparam int ADDR_W   = 16;
    localparam int CNT_LSB  = 16;
    localparam int CNT_W    = 16;

    function automatic int frame_bits(input int data_w, input int words);
        return data_w * words;
    endfunction

endpackage

// File: rtl/cfg_frame_loader_decoder.sv
// Registered binary-to-one-hot decoder; output is all zero unless en is high,
// and it clears asynchronously so the configuration latches close on reset.
module cfg_frame_decoder #(
    parameter int NUM_OUT = 64,
    parameter int IDX_W   = 16
) (
    input  logic               clk,
    input  logic               rn,
    input  logic               en,
    input  logic [IDX_W-1:0]   idx,
    output logic [NUM_OUT-1:0] onehot
);

    logic [NUM_OUT-1:0] dec;

    always_comb begin
        dec = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            dec[i] = en && (idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            onehot <= '0;
        end else begin
            onehot <= dec;
        end
    end

endmodule

// File: rtl/cfg_frame_loader.sv
// Configuration frame loader: assembles a word stream into frame-wide data and
// sequences setup, a one-hot latch-enable strobe and hold for each frame.
module cfg_frame_loader
    import cfg_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int WORDS_PER_FRAME = 4,
    parameter int NUM_FRAMES      = 64,
    parameter int EN_CYCLES       = 2
) (
    input  logic                                            clk,
    input  logic                                            rn,
    input  logic [DATA_W-1:0]                               in_data,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    input  logic                                            err_clr,
    output logic [frame_bits(DATA_W, WORDS_PER_FRAME)-1:0]  frame_data,
    output logic [NUM_FRAMES-1:0]                           frame_en,
    output logic                                            busy,
    output logic                                            done,
    output logic                                            err
);

    localparam int WCNT_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
    localparam int ECNT_W = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;
    localparam int SUM_W  = ADDR_W + 1;

    localparam logic [WCNT_W-1:0] LAST_WORD   = WCNT_W'(WORDS_PER_FRAME - 1);
    localparam logic [ECNT_W-1:0] LAST_EN     = ECNT_W'(EN_CYCLES - 1);
    localparam logic [SUM_W-1:0]  FRAME_LIMIT = SUM_W'(NUM_FRAMES);

    cfg_state_t        state;
    logic [ADDR_W-1:0] cur;
    logic [CNT_W-1:0]  remaining;
    logic [WCNT_W-1:0] wcnt;
    logic [ECNT_W-1:0] ecnt;

    logic [ADDR_W-1:0] hdr_addr;
    logic [CNT_W-1:0]  hdr_cnt;
    logic [SUM_W-1:0]  hdr_sum;
    logic              hdr_bad;
    logic              strobe_next;

    // A word moves on a rising edge where in_valid and in_ready are both high;
    // in_ready depends only on state, never on in_valid.
    assign in_ready = (state == IDLE) || (state == LOAD) || (state == ERR);
    assign busy     = (state != IDLE) && (state != ERR);
    assign err      = (state == ERR);

    assign hdr_addr = in_data[ADDR_LSB +: ADDR_W];
    assign hdr_cnt  = in_data[CNT_LSB +: CNT_W];
    assign hdr_sum  = {1'b0, hdr_addr} + {1'b0, hdr_cnt};
    assign hdr_bad  = (hdr_cnt == '0) || (hdr_sum > FRAME_LIMIT);

    // The decoder registers its output, so it is fed the state of the next cycle.
    assign strobe_next = (state == SETUP) || ((state == STROBE) && (ecnt != LAST_EN));

    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            state      <= IDLE;
            cur        <= '0;
            remaining  <= '0;
            wcnt       <= '0;
            ecnt       <= '0;
            frame_data <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (hdr_bad) begin
                            state <= ERR;
                        end else begin
                            state     <= LOAD;
                            cur       <= hdr_addr;
                            remaining <= hdr_cnt;
                            wcnt      <= '0;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        for (int k = 0; k < WORDS_PER_FRAME; k++) begin
                            if (wcnt == WCNT_W'(k)) begin
                                frame_data[k*DATA_W +: DATA_W] <= in_data;
                            end
                        end
                        if (wcnt == LAST_WORD) begin
                            state <= SETUP;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                SETUP: begin
                    ecnt  <= '0;
                    state <= STROBE;
                end
                STROBE: begin
                    if (ecnt == LAST_EN) begin
                        state <= HOLD;
                    end else begin
                        ecnt <= ecnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (remaining > CNT_W'(1)) begin
                        cur       <= cur + 1'b1;
                        remaining <= remaining - 1'b1;
                        wcnt      <= '0;
                        state     <= LOAD;
                    end else begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                ERR: begin
                    if (err_clr) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    cfg_frame_decoder #(
        .NUM_OUT(NUM_FRAMES),
        .IDX_W  (ADDR_W)
    ) u_decoder (
        .clk   (clk),
        .rn    (rn),
        .en    (strobe_next),
        .idx   (cur),
        .onehot(frame_en)
    );

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Self-checking bench for cfg_frame_loader: a transaction-level model predicts
// every output each cycle, plus literal checks on the directed scenarios.
module tb_cfg_frame_loader;

    localparam int DATA_W = 32;
    localparam int WPF    = 4;
    localparam int NF     = 64;
    localparam int EN     = 2;
    localparam int FB     = DATA_W * WPF;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_SEQ  = 2;
    localparam int M_ERR  = 3;

    logic              clk = 1'b0;
    logic              rn = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              err_clr = 1'b0;
    logic [FB-1:0]     frame_data;
    logic [NF-1:0]     frame_en;
    logic              busy;
    logic              done;
    logic              err;

    cfg_frame_loader #(
        .DATA_W         (DATA_W),
        .WORDS_PER_FRAME(WPF),
        .NUM_FRAMES     (NF),
        .EN_CYCLES      (EN)
    ) dut (
        .clk       (clk),
        .rn        (rn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .err_clr   (err_clr),
        .frame_data(frame_data),
        .frame_en  (frame_en),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [FB-1:0] act, input logic [FB-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int            m_mode = M_IDLE;
    int            m_cur = 0;
    int            m_rem = 0;
    int            m_wi = 0;
    int            m_k = 0;
    int            acc_cnt = 0;
    logic [FB-1:0] m_data = '0;
    logic          m_done = 1'b0;

    always @(posedge clk or negedge rn) begin
        int a;
        int n;
        if (!rn) begin
            m_mode = M_IDLE;
            m_cur  = 0;
            m_rem  = 0;
            m_wi   = 0;
            m_k    = 0;
            m_data = '0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (in_valid && m_mode != M_SEQ) acc_cnt++;
            case (m_mode)
                M_IDLE: if (in_valid) begin
                    a = in_data[15:0];
                    n = in_data[31:16];
                    if (n == 0 || a + n > NF) begin
                        m_mode = M_ERR;
                    end else begin
                        m_mode = M_LOAD;
                        m_cur  = a;
                        m_rem  = n;
                        m_wi   = 0;
                    end
                end
                M_LOAD: if (in_valid) begin
                    m_data[m_wi*DATA_W +: DATA_W] = in_data;
                    m_wi++;
                    if (m_wi == WPF) begin
                        m_mode = M_SEQ;
                        m_k    = 1;
                    end
                end
                M_SEQ: begin
                    // cycle 1 setup, 2..EN+1 strobe, EN+2 hold
                    if (m_k == EN + 2) begin
                        if (m_rem > 1) begin
                            m_cur++;
                            m_rem--;
                            m_wi   = 0;
                            m_mode = M_LOAD;
                        end else begin
                            m_mode = M_IDLE;
                            m_done = 1'b1;
                        end
                    end else begin
                        m_k++;
                    end
                end
                default: if (err_clr) m_mode = M_IDLE;
            endcase
        end
    end

    logic          exp_ready;
    logic          exp_busy;
    logic          exp_err;
    logic [NF-1:0] exp_en;
    assign exp_ready = (m_mode != M_SEQ);
    assign exp_busy  = (m_mode == M_LOAD) || (m_mode == M_SEQ);
    assign exp_err   = (m_mode == M_ERR);
    assign exp_en    = (m_mode == M_SEQ && m_k >= 2 && m_k <= EN + 1) ? (64'd1 << m_cur) : '0;

    // ---------------- per-cycle compare and strobe monitor ----------------
    logic [31:0]   exp_q[$];
    int            strobe_log[$];
    logic [NF-1:0] prev_en = '0;
    int            run_len = 0;
    int            done_cnt = 0;
    int            ready_low_cnt = 0;

    always @(negedge clk) begin
        int idx;
        check("in_ready", in_ready, exp_ready);
        check("frame_en", frame_en, exp_en);
        check("frame_data", frame_data, m_data);
        check("busy", busy, exp_busy);
        check("done", done, m_done);
        check("err", err, exp_err);
        check("onehot", $countones(frame_en) <= 1, 1);
        if (!rn) begin
            prev_en = '0;
            run_len = 0;
        end else begin
            if (done) done_cnt++;
            if (!in_ready) ready_low_cnt++;
            if (frame_en != '0 && prev_en == '0) begin
                idx = 0;
                for (int i = NF - 1; i >= 0; i--) if (frame_en[i]) idx = i;
                strobe_log.push_back(idx);
                check("strobe_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("strobe_index", idx, exp_q.pop_front());
                run_len = 1;
            end else if (frame_en != '0) begin
                run_len++;
            end else if (prev_en != '0) begin
                check("strobe_len", run_len, EN);
            end
            prev_en = frame_en;
        end
    end

    // ---------------- driver tasks (entered #1 after a rising edge) ----------------
    task automatic send_word(input logic [31:0] w, input int max_gap);
        int   gap;
        int   budget;
        logic r;
        gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_data  = w;
        in_valid = 1'b1;
        budget   = 100;
        r        = 1'b0;
        while (!r && budget > 0) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            budget--;
        end
        check("send_accepted", r, 1);
        in_valid = 1'b0;
    endtask

    task automatic send_frames(input int a, input int n, input int max_gap);
        send_word({n[15:0], a[15:0]}, max_gap);
        for (int i = 0; i < n * WPF; i++) send_word($urandom(), max_gap);
    endtask

    task automatic wait_idle(input int budget);
        int b;
        b = budget;
        do begin
            @(negedge clk);
            b--;
        end while (busy && b > 0);
        check("idle_reached", busy, 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    // ---------------- directed + randomized scenarios ----------------
    initial begin
        int d_done;
        int d_rdy;
        int d_acc;
        int d_str;
        logic [31:0] bad_hdr[2];

        repeat (3) @(posedge clk);
        #1;
        check("rst_frame_en", frame_en, 0);
        check("rst_frame_data", frame_data, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        #2 rn = 1'b1;
        @(posedge clk);
        #1;

        // single frame, literal timing
        d_done = done_cnt;
        d_rdy  = ready_low_cnt;
        exp_q.push_back(5);
        send_word({16'd1, 16'd5}, 0);
        send_word(32'h11111111, 0);
        send_word(32'h22222222, 0);
        send_word(32'h33333333, 0);
        send_word(32'h44444444, 0);
        check("s1_model_data", m_data, 128'h44444444_33333333_22222222_11111111);
        check("s1_setup_data", frame_data, 128'h44444444_33333333_22222222_11111111);
        check("s1_setup_en", frame_en, 0);
        @(posedge clk); #1;
        check("s1_strobe1", frame_en, 64'h20);
        @(posedge clk); #1;
        check("s1_strobe2", frame_en, 64'h20);
        @(posedge clk); #1;
        check("s1_hold_en", frame_en, 0);
        check("s1_hold_data", frame_data, 128'h44444444_33333333_22222222_11111111);
        @(posedge clk); #1;
        check("s1_done", done, 1);
        check("s1_idle", busy, 0);
        @(posedge clk); #1;
        check("s1_done_once", done_cnt - d_done, 1);
        check("s1_ready_low", ready_low_cnt - d_rdy, 4);

        // two frames at the top of the address space with random gaps
        d_done = done_cnt;
        exp_q.push_back(62);
        exp_q.push_back(63);
        send_frames(62, 2, 3);
        wait_idle(400);
        check("s2_first", strobe_log[strobe_log.size() - 2], 62);
        check("s2_second", strobe_log[strobe_log.size() - 1], 63);
        check("s2_done_once", done_cnt - d_done, 1);

        // rejected headers swallow words until err_clr
        bad_hdr[0] = {16'd2, 16'd63};
        bad_hdr[1] = {16'd0, 16'd0};
        for (int h = 0; h < 2; h++) begin
            d_str = strobe_log.size();
            send_word(bad_hdr[h], 0);
            check("s3_model_err", exp_err, 1);
            check("s3_err", err, 1);
            for (int i = 0; i < 10; i++) send_word($urandom(), 2);
            check("s3_err_held", err, 1);
            check("s3_no_strobe", strobe_log.size() - d_str, 0);
            pulse_err_clr();
            check("s3_cleared", err, 0);
            check("s3_cleared_busy", busy, 0);
        end
        exp_q.push_back(63);
        send_frames(63, 1, 1);
        wait_idle(200);
        check("s3_recover", strobe_log[strobe_log.size() - 1], 63);

        // asynchronous reset in the middle of a strobe
        exp_q.push_back(5);
        send_frames(5, 1, 0);
        @(posedge clk); #1;
        check("s4_strobing", frame_en, 64'h20);
        @(negedge clk);
        #2 rn = 1'b0;
        #1;
        check("s4_async_en", frame_en, 0);
        check("s4_async_data", frame_data, 0);
        check("s4_async_busy", busy, 0);
        @(negedge clk);
        #2 rn = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(10);
        send_frames(10, 1, 1);
        wait_idle(200);
        check("s4_fresh", strobe_log[strobe_log.size() - 1], 10);

        // full load of every frame
        d_done = done_cnt;
        d_acc  = acc_cnt;
        d_str  = strobe_log.size();
        for (int i = 0; i < NF; i++) exp_q.push_back(i);
        send_frames(0, NF, 1);
        wait_idle(400);
        check("s5_transfers", acc_cnt - d_acc, 257);
        check("s5_strobes", strobe_log.size() - d_str, NF);
        check("s5_done_once", done_cnt - d_done, 1);
        check("s5_queue_empty", exp_q.size(), 0);

        // err_clr together with a valid-looking header: word is dropped
        send_word({16'd0, 16'd0}, 0);
        check("s6_err", err, 1);
        in_data  = {16'd1, 16'd5};
        in_valid = 1'b1;
        err_clr  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        err_clr  = 1'b0;
        check("s6_err_left", err, 0);
        check("s6_not_loading", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        check("s6_still_idle", busy, 0);

        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
